// File: rtl/matrix_mult_pkg.sv
// Shared constants and types for the memory-mapped matrix multiplier.
package matrix_mult_pkg;

    // Default geometry and arithmetic widths.
    localparam int N_DEFAULT      = 4;
    localparam int ELEM_W_DEFAULT = 8;
    localparam int ACC_W_DEFAULT  = 32;

    // Register map.
    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_A    = 2'd1;
    localparam logic [1:0] ADDR_B    = 2'd2;
    localparam logic [1:0] ADDR_C    = 2'd3;

    // CTRL write bits and STATUS read bits.
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int STAT_DONE  = 0;
    localparam int STAT_BUSY  = 1;

    // Row-major element index into an N x N array.
    localparam int PTR_W = $clog2(N_DEFAULT * N_DEFAULT);
    typedef logic [PTR_W-1:0] ptr_t;

    // Sequencer states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/matrix_mult_mac.sv
// Signed multiply-accumulate datapath: one product per enabled cycle.
module matrix_mult_mac #(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic signed [ELEM_W-1:0] a_i,
    input  logic signed [ELEM_W-1:0] b_i,
    input  logic                     clear_acc_i,
    input  logic                     enable_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*ELEM_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_base;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;

    // Product is sign-extended before adding; the sum wraps modulo 2^ACC_W.
    // acc_o already includes the current product so the caller can store a
    // finished dot product on the same edge as its last term.
    always_comb begin
        prod     = a_i * b_i;
        acc_base = clear_acc_i ? '0 : acc_q;
        acc_o    = acc_base + ACC_W'(prod);
        acc_d    = enable_i ? acc_o : acc_q;
    end

    // Accumulator register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_mult.sv
// Memory-mapped N x N signed matrix multiplier (C = A x B) on an
// Avalon-MM style slave port with auto-incrementing data windows.
module matrix_mult
    import matrix_mult_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int ELEM_W = ELEM_W_DEFAULT,
    parameter int ACC_W  = ACC_W_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic        read
);

    localparam int NN     = N * N;
    localparam int PW     = (NN > 1) ? $clog2(NN) : 1;
    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    // Storage.
    logic signed [ELEM_W-1:0] a_mem_q [NN];
    logic signed [ELEM_W-1:0] b_mem_q [NN];
    logic signed [ACC_W-1:0]  c_mem_q [NN];

    // Control state.
    state_e          state_q, state_d;
    logic            done_q, done_d;
    logic [PW-1:0]   a_ptr_q, a_ptr_d;
    logic [PW-1:0]   b_ptr_q, b_ptr_d;
    logic [PW-1:0]   c_ptr_q, c_ptr_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic [IW-1:0]   p_q, p_d;
    logic [31:0]     readdata_q, readdata_d;

    // Decoded bus actions and sequencer strobes.
    logic                     busy;
    logic                     clear_cmd;
    logic                     start_cmd;
    logic                     a_wr;
    logic                     b_wr;
    logic                     c_rd;
    logic                     run_step;
    logic                     last_p;
    logic                     last_j;
    logic                     last_i;
    logic [PW-1:0]            a_idx;
    logic [PW-1:0]            b_idx;
    logic [PW-1:0]            c_idx;
    logic signed [ACC_W-1:0]  acc;
    logic                     unused_wdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
        return (v == PTR_LAST) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] v);
        return (v == IDX_LAST) ? '0 : v + 1'b1;
    endfunction

    // Upper write-data bits beyond an element carry no meaning.
    assign unused_wdata = ^writedata[31:ELEM_W];

    // Bus decode: CLEAR is applied before START, so a combined write restarts
    // even an active run; a lone START is dropped while busy.
    always_comb begin
        busy      = (state_q == ST_RUN);
        clear_cmd = write && (address == ADDR_CTRL) && writedata[CTRL_CLEAR];
        start_cmd = write && (address == ADDR_CTRL) && writedata[CTRL_START]
                    && (!busy || clear_cmd);
        a_wr      = write && (address == ADDR_A) && !busy;
        b_wr      = write && (address == ADDR_B) && !busy;
        c_rd      = read && (address == ADDR_C);
        run_step  = busy && !clear_cmd;
        last_p    = (p_q == IDX_LAST);
        last_j    = (j_q == IDX_LAST);
        last_i    = (i_q == IDX_LAST);
        a_idx     = PW'(int'(i_q) * N + int'(p_q));
        b_idx     = PW'(int'(p_q) * N + int'(j_q));
        c_idx     = PW'(int'(i_q) * N + int'(j_q));
    end

    matrix_mult_mac #(
        .ELEM_W (ELEM_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i       (clock),
        .rst_ni      (resetn),
        .a_i         (a_mem_q[a_idx]),
        .b_i         (b_mem_q[b_idx]),
        .clear_acc_i (p_q == '0),
        .enable_i    (run_step),
        .acc_o       (acc)
    );

    // Next-state for the sequencer, pointers and status.
    // NOTE: every output gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        a_ptr_d = a_ptr_q;
        b_ptr_d = b_ptr_q;
        c_ptr_d = c_ptr_q;
        i_d     = i_q;
        j_d     = j_q;
        p_d     = p_q;

        if (a_wr) a_ptr_d = ptr_inc(a_ptr_q);
        if (b_wr) b_ptr_d = ptr_inc(b_ptr_q);
        if (c_rd) c_ptr_d = ptr_inc(c_ptr_q);

        if (run_step) begin
            p_d = idx_inc(p_q);
            if (last_p) begin
                j_d = idx_inc(j_q);
                if (last_j) begin
                    i_d = idx_inc(i_q);
                    if (last_i) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        end

        if (clear_cmd) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            a_ptr_d = '0;
            b_ptr_d = '0;
            c_ptr_d = '0;
        end

        if (start_cmd) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
            c_ptr_d = '0;
            i_d     = '0;
            j_d     = '0;
            p_d     = '0;
        end
    end

    // Registered read data: refreshed only on read cycles, from pre-edge state.
    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            unique case (address)
                ADDR_CTRL: begin
                    readdata_d            = '0;
                    readdata_d[STAT_BUSY] = busy;
                    readdata_d[STAT_DONE] = done_q;
                end
                ADDR_A:    readdata_d = 32'(a_ptr_q);
                ADDR_B:    readdata_d = 32'(b_ptr_q);
                ADDR_C:    readdata_d = 32'(c_mem_q[c_ptr_q]);
                default:   readdata_d = readdata_q;
            endcase
        end
    end

    // Control and read-data registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            a_ptr_q    <= '0;
            b_ptr_q    <= '0;
            c_ptr_q    <= '0;
            i_q        <= '0;
            j_q        <= '0;
            p_q        <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            a_ptr_q    <= a_ptr_d;
            b_ptr_q    <= b_ptr_d;
            c_ptr_q    <= c_ptr_d;
            i_q        <= i_d;
            j_q        <= j_d;
            p_q        <= p_d;
            readdata_q <= readdata_d;
        end
    end

    // Matrix storage: A/B loaded from the bus, C cleared on START and filled
    // with each finished dot product.
    // NOTE: the arrays are reset because software-visible contents must read 0 after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NN; k++) begin
                a_mem_q[k] <= '0;
                b_mem_q[k] <= '0;
                c_mem_q[k] <= '0;
            end
        end else begin
            if (a_wr) a_mem_q[a_ptr_q] <= writedata[ELEM_W-1:0];
            if (b_wr) b_mem_q[b_ptr_q] <= writedata[ELEM_W-1:0];
            if (start_cmd) begin
                for (int k = 0; k < NN; k++) begin
                    c_mem_q[k] <= '0;
                end
            end else if (run_step && last_p) begin
                c_mem_q[c_idx] <= acc;
            end
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_matrix_mult.sv
// Directed self-checking bench for matrix_mult (N=4, ELEM_W=8, ACC_W=32).
module tb_matrix_mult;
    import matrix_mult_pkg::*;

    logic        clock     = 1'b0;
    logic        resetn    = 1'b0;
    logic [1:0]  address   = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        write     = 1'b0;
    logic        read      = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] a_vec [16];
    logic [7:0] b_vec [16];

    matrix_mult dut (
        .clock     (clock),
        .resetn    (resetn),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .write     (write),
        .read      (read)
    );

    always #5 clock = ~clock;

    // Each bus task starts and ends on a falling edge and spans one rising edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        address = addr;
        read    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        read    = 1'b0;
        data    = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load_ab();
        for (int k = 0; k < 16; k++) bus_write(ADDR_A, {24'b0, a_vec[k]});
        for (int k = 0; k < 16; k++) bus_write(ADDR_B, {24'b0, b_vec[k]});
    endtask

    // Polls status until done; returns the last status and poll count.
    task automatic poll_done(output logic [31:0] st, output int polls);
        polls = 0;
        do begin
            bus_read(ADDR_CTRL, st);
            polls++;
        end while (st !== 32'h1 && polls < 200);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #12;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata: got %08h expected %08h", readdata, 32'h0);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %08h expected %08h", rd, 32'h0);
        end
        bus_read(ADDR_A, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_a_ptr: got %08h expected %08h", rd, 32'h0);
        end
        bus_read(ADDR_B, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_b_ptr: got %08h expected %08h", rd, 32'h0);
        end
    endtask

    task automatic test_identity();
        logic [31:0] rd;
        int          polls;
        bus_write(ADDR_CTRL, 32'h2);
        for (int k = 0; k < 16; k++) begin
            a_vec[k] = (k % 5 == 0) ? 8'd1 : 8'd0;
            b_vec[k] = 8'(k + 1);
        end
        load_ab();
        bus_read(ADDR_A, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL identity_a_ptr_wrap: got %08h expected %08h", rd, 32'h0);
        end
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(rd, polls);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL identity_done: got %08h expected %08h after %0d polls", rd, 32'h1, polls);
        end
        for (int k = 0; k < 16; k++) begin
            bus_read(ADDR_C, rd);
            checks++;
            if (rd !== 32'(k + 1)) begin
                errors++;
                $display("FAIL identity_c[%0d]: got %08h expected %08h", k, rd, 32'(k + 1));
            end
        end
    endtask

    task automatic test_constant();
        logic [31:0] rd;
        bus_write(ADDR_CTRL, 32'h2);
        for (int k = 0; k < 16; k++) begin
            a_vec[k] = 8'd2;
            b_vec[k] = 8'd3;
        end
        load_ab();
        bus_write(ADDR_CTRL, 32'h1);
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL constant_busy: got %08h expected %08h", rd, 32'h2);
        end
        idle(70);
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL constant_done: got %08h expected %08h", rd, 32'h1);
        end
        for (int k = 0; k < 16; k++) begin
            bus_read(ADDR_C, rd);
            checks++;
            if (rd !== 32'h18) begin
                errors++;
                $display("FAIL constant_c[%0d]: got %08h expected %08h", k, rd, 32'h18);
            end
        end
    endtask

    task automatic test_signed();
        logic [31:0] rd;
        logic [31:0] exp;
        int          polls;
        bus_write(ADDR_CTRL, 32'h2);
        for (int k = 0; k < 16; k++) begin
            a_vec[k] = 8'h00;
            b_vec[k] = 8'h00;
        end
        a_vec[0] = 8'hFF;
        b_vec[0] = 8'h05;
        load_ab();
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(rd, polls);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL signed_done: got %08h expected %08h after %0d polls", rd, 32'h1, polls);
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k == 0) ? 32'hFFFF_FFFB : 32'h0;
            bus_read(ADDR_C, rd);
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL signed_c[%0d]: got %08h expected %08h", k, rd, exp);
            end
        end
    endtask

    // START lands on edge k; the run must finish on edge k+64 regardless of
    // the A write and second START issued during it.
    task automatic test_busy_protect();
        logic [31:0] rd;
        bus_write(ADDR_CTRL, 32'h2);
        for (int k = 0; k < 16; k++) begin
            a_vec[k] = 8'd1;
            b_vec[k] = 8'd1;
        end
        load_ab();
        bus_write(ADDR_CTRL, 32'h1);    // edge k
        bus_write(ADDR_A, 32'h7F);      // edge k+1, ignored
        bus_read(ADDR_A, rd);           // edge k+2
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL busy_a_ptr_frozen: got %08h expected %08h", rd, 32'h0);
        end
        bus_write(ADDR_CTRL, 32'h1);    // edge k+3, ignored
        idle(60);                       // edges k+4 .. k+63
        bus_read(ADDR_CTRL, rd);        // edge k+64, pre-edge still busy
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL busy_status_k64: got %08h expected %08h", rd, 32'h2);
        end
        bus_read(ADDR_CTRL, rd);        // edge k+65
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL busy_status_k65: got %08h expected %08h", rd, 32'h1);
        end
        for (int k = 0; k < 16; k++) begin
            bus_read(ADDR_C, rd);
            checks++;
            if (rd !== 32'h4) begin
                errors++;
                $display("FAIL busy_c[%0d]: got %08h expected %08h", k, rd, 32'h4);
            end
        end
    endtask

    task automatic test_wrap_clear();
        logic [31:0] rd;
        logic [31:0] exp;
        ptr_t        exp_ptr;
        int          polls;
        bus_write(ADDR_CTRL, 32'h2);
        for (int k = 0; k < 17; k++) begin
            bus_write(ADDR_A, (k == 16) ? 32'h33 : 32'(8'h11 + k));
        end
        exp_ptr = ptr_t'(17);
        bus_read(ADDR_A, rd);
        checks++;
        if (rd !== 32'(exp_ptr)) begin
            errors++;
            $display("FAIL wrap_a_ptr: got %08h expected %08h", rd, 32'(exp_ptr));
        end
        for (int k = 0; k < 16; k++) begin
            bus_write(ADDR_B, (k % 5 == 0) ? 32'h1 : 32'h0);
        end
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(rd, polls);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL wrap_done: got %08h expected %08h after %0d polls", rd, 32'h1, polls);
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k == 0) ? 32'h33 : 32'(8'h11 + k);
            bus_read(ADDR_C, rd);
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL wrap_c[%0d]: got %08h expected %08h", k, rd, exp);
            end
        end
        for (int k = 0; k < 3; k++) bus_read(ADDR_C, rd);
        bus_write(ADDR_CTRL, 32'h2);
        bus_read(ADDR_A, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL clear_a_ptr: got %08h expected %08h", rd, 32'h0);
        end
        bus_read(ADDR_B, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL clear_b_ptr: got %08h expected %08h", rd, 32'h0);
        end
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL clear_status: got %08h expected %08h", rd, 32'h0);
        end
        bus_read(ADDR_C, rd);
        checks++;
        if (rd !== 32'h33) begin
            errors++;
            $display("FAIL clear_c_ptr: got %08h expected %08h", rd, 32'h33);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int          polls;
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CTRL, 32'h2);
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL abort_status: got %08h expected %08h", rd, 32'h0);
        end
        idle(70);
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_done: got %08h expected %08h", rd, 32'h0);
        end
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CTRL, 32'h3);
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL start_clear_busy: got %08h expected %08h", rd, 32'h2);
        end
        poll_done(rd, polls);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL start_clear_done: got %08h expected %08h after %0d polls", rd, 32'h1, polls);
        end
    endtask

    // Read and write to A_DATA on the same edge: read sees the old pointer.
    task automatic test_read_write_same_cycle();
        logic [31:0] rd;
        bus_write(ADDR_CTRL, 32'h2);
        bus_write(ADDR_A, 32'h5);
        address   = ADDR_A;
        writedata = 32'h6;
        write     = 1'b1;
        read      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        write     = 1'b0;
        read      = 1'b0;
        checks++;
        if (readdata !== 32'h1) begin
            errors++;
            $display("FAIL rw_pre_write_ptr: got %08h expected %08h", readdata, 32'h1);
        end
        bus_read(ADDR_A, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL rw_post_write_ptr: got %08h expected %08h", rd, 32'h2);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_constant();
        test_signed();
        test_busy_protect();
        test_wrap_clear();
        test_abort();
        test_read_write_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a bus task never returns.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
